// File: rtl/fb_window_fetch_if.sv
// ============================================================================
//  Module   : fb_window_fetch_if
//  Purpose  : Bundles the VGA, frame-buffer read port and classifier fetch
//             signals used by fb_window_fetch.
//             slave  - the scheduler side; master - its environment.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fb_window_fetch_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 4
);
  logic              vga_active;
  logic [ADDR_W-1:0] vga_addr;
  logic [PIX_W-1:0]  vga_pixel;
  logic [ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              cl_start;
  logic [ADDR_W-1:0] cl_base;
  logic              cl_busy;
  logic              cl_valid;
  logic [PIX_W-1:0]  cl_data;
  logic              cl_done;

  modport slave (
    input  vga_active, vga_addr, fb_data, cl_start, cl_base,
    output vga_pixel, fb_addr, cl_busy, cl_valid, cl_data, cl_done
  );

  modport master (
    output vga_active, vga_addr, fb_data, cl_start, cl_base,
    input  vga_pixel, fb_addr, cl_busy, cl_valid, cl_data, cl_done
  );
endinterface

`default_nettype wire

// File: rtl/fb_window_fetch.sv
// ============================================================================
//  Module   : fb_window_fetch
//  Purpose  : Shares the frame-buffer read port between VGA scan-out (absolute
//             priority while visible) and a strided WIN_W x WIN_H window fetch
//             for the classifier, issued only in blanking cycles.
//  Option   : FB_WINDOW_FETCH_STALL_CNT_EN adds a 16-bit saturating stall_cnt
//             output counting FETCH cycles blocked by vga_active.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_window_fetch #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 4,
  parameter int H_REZ  = 640,
  parameter int RD_LAT = 1,
  parameter int WIN_W  = 28,
  parameter int WIN_H  = 28,
  parameter int STEP   = 16
) (
  input  logic             clk24,
  input  logic             rst,
  fb_window_fetch_if.slave bus
`ifdef FB_WINDOW_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int COL_W = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam int ROW_W = (WIN_H > 1) ? $clog2(WIN_H) : 1;

  localparam logic [ADDR_W-1:0] c_col_step = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(H_REZ * STEP);
  localparam logic [COL_W-1:0]  c_col_last = COL_W'(WIN_W - 1);
  localparam logic [ROW_W-1:0]  c_row_last = ROW_W'(WIN_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_busy;
  logic              w_issue;
  logic              w_accept;
  logic              w_drain_done;
  logic              w_last_pos;
  logic [RD_LAT-1:0] r_tag;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_col_addr;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_cl_valid;
  logic [PIX_W-1:0]  r_cl_data;
  logic              r_cl_done;

  assign w_last_pos = (r_col == c_col_last) && (r_row == c_row_last);

  // State register
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; a fetch read only goes out when VGA leaves the port free
  always_comb begin
    w_next       = r_state;
    w_busy       = 1'b0;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cl_start) begin
          w_accept = 1'b1;
          w_next   = FETCH;
        end
      end
      FETCH: begin
        w_busy = 1'b1;
        if (!bus.vga_active) begin
          w_issue = 1'b1;
          if (w_last_pos) w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_busy = 1'b1;
        // Tag pipe empty means the final pixel is being presented this cycle
        if (r_tag == '0) begin
          w_drain_done = 1'b1;
          w_next       = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Window walk: column stride within a row, row pitch times stride between rows
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_row_base <= '0;
      r_col_addr <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else if (w_accept) begin
      r_row_base <= bus.cl_base;
      r_col_addr <= bus.cl_base;
      r_col      <= '0;
      r_row      <= '0;
    end else if (w_issue) begin
      if (r_col != c_col_last) begin
        r_col      <= r_col + 1'b1;
        r_col_addr <= r_col_addr + c_col_step;
      end else begin
        r_col      <= '0;
        r_row      <= r_row + 1'b1;
        r_row_base <= r_row_base + c_row_step;
        r_col_addr <= r_row_base + c_row_step;
      end
    end
  end

  // Tag pipeline marks which returning read words belong to the fetch
  generate
    if (RD_LAT == 1) begin : g_tag_lat1
      always_ff @(posedge clk24 or posedge rst) begin
        if (rst) r_tag <= '0;
        else     r_tag <= w_issue;
      end
    end else begin : g_tag_latn
      always_ff @(posedge clk24 or posedge rst) begin
        if (rst) r_tag <= '0;
        else     r_tag <= {r_tag[RD_LAT-2:0], w_issue};
      end
    end
  endgenerate

  // Capture fetched pixels as the tag emerges; done follows the last valid
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_cl_valid <= 1'b0;
      r_cl_data  <= '0;
      r_cl_done  <= 1'b0;
    end else begin
      r_cl_valid <= r_tag[RD_LAT-1];
      if (r_tag[RD_LAT-1]) r_cl_data <= bus.fb_data;
      r_cl_done  <= w_drain_done;
    end
  end

`ifdef FB_WINDOW_FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of fetch cycles lost to VGA scan-out
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst)                                 r_stall_cnt <= '0;
    else if (w_accept)                       r_stall_cnt <= '0;
    else if ((r_state == FETCH) && bus.vga_active && (r_stall_cnt != 16'hFFFF))
                                             r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign bus.fb_addr   = ((r_state == FETCH) && !bus.vga_active) ? r_col_addr : bus.vga_addr;
  assign bus.vga_pixel = bus.fb_data;
  assign bus.cl_busy   = w_busy;
  assign bus.cl_valid  = r_cl_valid;
  assign bus.cl_data   = r_cl_data;
  assign bus.cl_done   = r_cl_done;

endmodule

`default_nettype wire

// File: doc/fb_window_fetch.md
# fb_window_fetch

Frame-buffer read-port scheduler that shares the single greyscale frame-buffer read port between VGA scan-out and a subsampled window fetch for the LeNet classifier. VGA scan-out has absolute priority during the visible region. On command, the block walks a WIN_W x WIN_H grid of pixels at stride STEP from a base address, issuing reads only in VGA blanking cycles. It returns the fetched pixels as a valid-qualified stream. It sits between the VGA timing generator, the frame-buffer BRAM read port and the LeNet input loader.

## Interface
- ADDR_W, 19, frame-buffer address width
- PIX_W, 4, pixel width
- H_REZ, 640, frame line length in pixels; row pitch of the buffer
- RD_LAT, 1, BRAM read latency in cycles (1..3)
- WIN_W, 28, window columns
- WIN_H, 28, window rows
- STEP, 16, subsample stride in both axes

Ports (one clock; reset is asynchronous and active-high):
- clk24  in  1  pixel/system clock
- rst  in  1  asynchronous active-high reset
- vga_active  in  1  VGA visible-region read this cycle
- vga_addr  in  ADDR_W  VGA scan-out address
- vga_pixel  out  PIX_W  read data for VGA; equals fb_data
- fb_addr  out  ADDR_W  frame-buffer read address
- fb_data  in  PIX_W  frame-buffer read data, RD_LAT after fb_addr
- cl_start  in  1  one-cycle fetch command
- cl_base  in  ADDR_W  window top-left address, sampled with cl_start
- cl_busy  out  1  fetch in progress, including drain
- cl_valid  out  1  cl_data valid
- cl_data  out  PIX_W  fetched pixel, raster order within window
- cl_done  out  1  one-cycle pulse after the last cl_valid

## Operation
- FSM states:
  - IDLE: cl_start loads row_base = col_addr = cl_base, col = row = 0, and moves to FETCH.
  - FETCH: on each cycle with vga_active = 0, issue one read at col_addr.
    - If col < WIN_W-1: col_addr += STEP.
    - Else: col = 0, row_base += H_REZ*STEP, col_addr = new row_base.
    - After issuing (WIN_W-1, WIN_H-1), move to DRAIN.
  - DRAIN: wait until the tag pipeline is empty, pulse cl_done, then return to IDLE.
- fb_addr is combinational:
  - vga_active = 1: vga_addr.
  - Else, FETCH: col_addr.
  - Else: vga_addr.
- Tag pipeline: an RD_LAT-deep shift register marks fetch-issued reads. cl_valid/cl_data are registered from fb_data when the tag emerges.
- Address arithmetic is modulo 2^ADDR_W with no clamping. Keeping the window inside the frame is the caller's responsibility.
- cl_start is ignored while cl_busy = 1.
- cl_busy = 1 in FETCH and DRAIN.
- Exactly WIN_W*WIN_H cl_valid pulses per command.

## Timing
- Reset values:
  - fb_addr = vga_addr (combinational).
  - cl_busy, cl_valid, cl_done = 0; cl_data = 0.
  - FSM = IDLE; tag pipeline cleared.
- Reset mid-fetch aborts the fetch. In-flight data is discarded and no cl_valid or cl_done follows.
- The first read is issued in the cycle after cl_start, provided vga_active = 0 in that cycle.
- cl_valid follows its issue cycle by RD_LAT+1 cycles.
- cl_done is asserted one cycle after the final cl_valid.
- vga_pixel is combinational pass-through. The VGA pipeline is unaffected by fetch activity.
- Throughput is one pixel per blanking cycle; zero in visible cycles.

## Configuration
- FB_WINDOW_FETCH_STALL_CNT_EN defined:
  - Adds output stall_cnt [15:0]: counts FETCH cycles blocked by vga_active = 1.
  - Saturates at 0xFFFF.
  - Cleared on accepted cl_start and on reset.
  - Holds its value after cl_done.
- Undefined: no stall_cnt port and no counter logic.

## Test plan
- Reset: assert rst with vga_active = 0 -> cl_busy = cl_valid = cl_done = 0, fb_addr = vga_addr.
- vga_active held 0, cl_start with cl_base = 0 (RD_LAT = 1, BRAM data = addr[3:0]):
  - Exactly 784 cl_valid pulses.
  - Address sequence 0, 16, 32, …, 432, then 10240, 10256, ….
  - Last address 276912.
  - cl_done one cycle after the 784th cl_valid; last issue-to-done = 3 cycles.
- vga_active toggling 1 cycle on / 1 cycle off:
  - fb_addr = vga_addr in every active cycle.
  - vga_pixel is correct.
  - Fetch completes in ~1568 cycles with the sequence unchanged.
- cl_start pulsed mid-fetch with a different cl_base -> ignored; sequence and count unchanged.
- rst asserted after 100 cl_valid pulses, then released -> no further cl_valid and no cl_done; a new cl_start restarts from its own base.
- With FB_WINDOW_FETCH_STALL_CNT_EN, vga_active forced 1 for 50 cycles during FETCH -> stall_cnt = 50 at cl_done.
